// File: rtl/fb_pkg.sv
// Shared types and constants for the double-buffered frame store.
package fb_pkg;

  typedef logic [2:0][7:0] color_t;  // {B,G,R}

  localparam int unsigned H_RES        = 160;
  localparam int unsigned V_RES        = 120;
  localparam int unsigned SCALE_SH     = 2;
  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_V_ACTIVE = 480;

  typedef enum logic [1:0] {
    StRender,
    StWaitVb,
    StSwap
  } fb_state_e;

  // Multiply by a constant as a sum of shifted copies; folds to shift-adds for fixed k.
  function automatic logic [19:0] mul_const(input logic [9:0] a, input int unsigned k);
    logic [19:0] acc;
    acc = '0;
    for (int i = 0; i < 20; i++) begin
      if (k[i]) acc = acc + (20'(a) << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/fb_dual_port_ram.sv
// Simple dual-port frame RAM: one write port, one registered read port, no reset.
module fb_dual_port_ram #(
  parameter int unsigned AddrW = 16,
  parameter int unsigned DataW = 24
) (
  input  logic             i_clk,
  input  logic             i_wr_en,
  input  logic [AddrW-1:0] i_wr_addr,
  input  logic [DataW-1:0] i_wr_data,
  input  logic [AddrW-1:0] i_rd_addr,
  output logic [DataW-1:0] o_rd_data
);

  // Banks sit at a power-of-two stride so the bank bit is simply the address MSB.
  logic [DataW-1:0] r_mem [2**AddrW];
  logic [DataW-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fb_swap_ctrl.sv
// Double-buffered frame store: renderer writes the back bank, VGA reads the front bank,
// banks flip only on a vertical-blank rising edge after the renderer finishes a frame.
module fb_swap_ctrl #(
  parameter int unsigned H_RES    = fb_pkg::H_RES,
  parameter int unsigned V_RES    = fb_pkg::V_RES,
  parameter int unsigned SCALE_SH = fb_pkg::SCALE_SH,
  parameter int unsigned COLOR_W  = 24
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Write,
  input  logic [9:0]         WriteX,
  input  logic [9:0]         WriteY,
  input  logic [COLOR_W-1:0] WriteColor,
  output logic               Write_ready,
  input  logic               Frame_Done,
  input  logic               VBlank,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  output logic [COLOR_W-1:0] ReadColor,
  output logic               Front_sel,
  output logic [15:0]        Swap_count,
  output logic [7:0]         Dropped
);
  import fb_pkg::*;

  localparam int unsigned PixAw = $clog2(H_RES * V_RES);
  localparam int unsigned AddrW = PixAw + 1;

  fb_state_e    r_state;
  logic         r_write_ready;
  logic         r_front_sel;
  logic         r_vblank_q;
  logic [15:0]  r_swap_count;
  logic [7:0]   r_dropped;

  logic [AddrW-1:0]   r_rd_addr;
  logic               r_rd_zero;
  logic               r_out_zero;
  logic [COLOR_W-1:0] w_ram_q;

  logic             w_vb_rise;
  logic             w_wr_in_range;
  logic             w_wr_en;
  logic [PixAw-1:0] w_wr_off;
  logic [AddrW-1:0] w_wr_addr;
  logic [9:0]       w_rd_x;
  logic [9:0]       w_rd_y;
  logic [PixAw-1:0] w_rd_off;
  logic             w_rd_oob;

  assign w_vb_rise     = VBlank & ~r_vblank_q;
  assign w_wr_in_range = (WriteX < 10'(H_RES)) && (WriteY < 10'(V_RES));
  assign w_wr_en       = Write & r_write_ready & w_wr_in_range;
  assign w_wr_off      = PixAw'(mul_const(WriteY, H_RES)) + PixAw'(WriteX);
  assign w_wr_addr     = {~r_front_sel, w_wr_off};

  assign w_rd_x   = DrawX >> SCALE_SH;
  assign w_rd_y   = DrawY >> SCALE_SH;
  assign w_rd_off = PixAw'(mul_const(w_rd_y, H_RES)) + PixAw'(w_rd_x);
  assign w_rd_oob = (DrawX >= 10'(VGA_H_ACTIVE)) || (DrawY >= 10'(VGA_V_ACTIVE));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state       <= StRender;
      r_write_ready <= 1'b1;
      r_front_sel   <= 1'b0;
      r_vblank_q    <= 1'b0;
      r_swap_count  <= '0;
      r_dropped     <= '0;
    end else begin
      r_vblank_q <= VBlank;
      if (Frame_Done && (r_state != StRender) && (r_dropped != 8'hFF)) begin
        r_dropped <= r_dropped + 8'd1;
      end
      unique case (r_state)
        StRender: begin
          if (Frame_Done) begin
            r_state       <= StWaitVb;
            r_write_ready <= 1'b0;
          end
        end
        StWaitVb: begin
          if (w_vb_rise) r_state <= StSwap;
        end
        StSwap: begin
          r_front_sel   <= ~r_front_sel;
          r_swap_count  <= r_swap_count + 16'd1;
          r_write_ready <= 1'b1;
          r_state       <= StRender;
        end
        default: begin
          r_state       <= StRender;
          r_write_ready <= 1'b1;
        end
      endcase
    end
  end

  // Zero flag rides alongside the address so blanked pixels line up with RAM latency.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rd_addr  <= '0;
      r_rd_zero  <= 1'b1;
      r_out_zero <= 1'b1;
    end else begin
      r_rd_addr  <= {r_front_sel, w_rd_off};
      r_rd_zero  <= w_rd_oob;
      r_out_zero <= r_rd_zero;
    end
  end

  fb_dual_port_ram #(
    .AddrW(AddrW),
    .DataW(COLOR_W)
  ) u_ram (
    .i_clk    (Clk),
    .i_wr_en  (w_wr_en),
    .i_wr_addr(w_wr_addr),
    .i_wr_data(WriteColor),
    .i_rd_addr(r_rd_addr),
    .o_rd_data(w_ram_q)
  );

  assign ReadColor   = r_out_zero ? '0 : w_ram_q;
  assign Write_ready = r_write_ready;
  assign Front_sel   = r_front_sel;
  assign Swap_count  = r_swap_count;
  assign Dropped     = r_dropped;

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Bench for fb_swap_ctrl: bank model plus a read scoreboard keyed by issue cycle.
module tb_fb_swap_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Write;
  logic [9:0]  WriteX, WriteY;
  logic [23:0] WriteColor;
  logic        Write_ready;
  logic        Frame_Done;
  logic        VBlank;
  logic [9:0]  DrawX, DrawY;
  logic [23:0] ReadColor;
  logic        Front_sel;
  logic [15:0] Swap_count;
  logic [7:0]  Dropped;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit exp_front = 1'b0;

  logic [23:0] model [int];
  int          req_x[$], req_y[$];
  logic [23:0] exp_q[$];
  int          stamp_q[$];
  int          ex_q[$], ey_q[$];

  always #5 Clk = ~Clk;

  fb_swap_ctrl dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Write      (Write),
    .WriteX     (WriteX),
    .WriteY     (WriteY),
    .WriteColor (WriteColor),
    .Write_ready(Write_ready),
    .Frame_Done (Frame_Done),
    .VBlank     (VBlank),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .ReadColor  (ReadColor),
    .Front_sel  (Front_sel),
    .Swap_count (Swap_count),
    .Dropped    (Dropped)
  );

  function automatic int key(input bit b, input int x, input int y);
    return (b ? 65536 : 0) + y * 256 + x;
  endfunction

  function automatic logic [23:0] exp_color(input int dx, input int dy);
    if (dx >= 640 || dy >= 480) return 24'h0;
    return model[key(exp_front, dx >> 2, dy >> 2)];
  endfunction

  task automatic tick;
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic do_write(input int x, input int y, input logic [23:0] c, input bit fd);
    Write = 1'b1; WriteX = 10'(x); WriteY = 10'(y); WriteColor = c; Frame_Done = fd;
    n_checks++;
    if (Write_ready !== 1'b1)
      $display("FAIL write_ready x=%0d y=%0d got %b want 1", x, y, Write_ready);
    else n_pass++;
    if (x < 160 && y < 120) model[key(!exp_front, x, y)] = c;
    tick;
    Write = 1'b0; Frame_Done = 1'b0;
  endtask

  task automatic add_read(input int x, input int y);
    req_x.push_back(x); req_y.push_back(y);
  endtask

  // Issue queued reads one per cycle; each result is due exactly two cycles after issue.
  task automatic run_reads(input string tag);
    while (req_x.size() > 0 || exp_q.size() > 0) begin
      if (exp_q.size() > 0 && stamp_q[0] + 2 <= cyc) begin
        logic [23:0] e;
        int ex, ey;
        e = exp_q.pop_front(); void'(stamp_q.pop_front());
        ex = ex_q.pop_front(); ey = ey_q.pop_front();
        n_checks++;
        if (ReadColor !== e)
          $display("FAIL %s read (%0d,%0d) got %h want %h", tag, ex, ey, ReadColor, e);
        else n_pass++;
      end
      if (req_x.size() > 0) begin
        int x, y;
        x = req_x.pop_front(); y = req_y.pop_front();
        DrawX = 10'(x); DrawY = 10'(y);
        exp_q.push_back(exp_color(x, y)); stamp_q.push_back(cyc);
        ex_q.push_back(x); ey_q.push_back(y);
      end
      tick;
    end
  endtask

  task automatic test_reset;
    Reset_n = 1'b0; Write = 1'b0; WriteX = '0; WriteY = '0; WriteColor = '0;
    Frame_Done = 1'b0; VBlank = 1'b0; DrawX = '0; DrawY = '0;
    repeat (3) tick;
    Reset_n = 1'b1;
    #1;
    n_checks++; if (Front_sel !== 1'b0) $display("FAIL rst_front got %b want 0", Front_sel); else n_pass++;
    n_checks++; if (Write_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", Write_ready); else n_pass++;
    n_checks++; if (ReadColor !== 24'h0) $display("FAIL rst_color got %h want 0", ReadColor); else n_pass++;
    n_checks++; if (Swap_count !== 16'h0) $display("FAIL rst_swaps got %0d want 0", Swap_count); else n_pass++;
    n_checks++; if (Dropped !== 8'h0) $display("FAIL rst_dropped got %0d want 0", Dropped); else n_pass++;
    // Write offered in the first cycle out of reset must be taken.
    do_write(0, 0, 24'hAAAAAA, 1'b0);
  endtask

  task automatic test_write_swap;
    do_write(5, 7, 24'h112233, 1'b0);
    do_write(159, 119, 24'h5A5A5A, 1'b1);
    n_checks++; if (Write_ready !== 1'b0) $display("FAIL ws_ready_drop got %b want 0", Write_ready); else n_pass++;
    VBlank = 1'b1;
    tick;
    n_checks++; if (Front_sel !== 1'b0) $display("FAIL ws_front_k got %b want 0", Front_sel); else n_pass++;
    tick;
    n_checks++; if (Front_sel !== 1'b1) $display("FAIL ws_front_k1 got %b want 1", Front_sel); else n_pass++;
    n_checks++; if (Write_ready !== 1'b1) $display("FAIL ws_ready_back got %b want 1", Write_ready); else n_pass++;
    n_checks++; if (Swap_count !== 16'd1) $display("FAIL ws_swaps got %0d want 1", Swap_count); else n_pass++;
    exp_front = 1'b1;
    VBlank = 1'b0;
    tick;
    for (int y = 28; y < 32; y++) for (int x = 20; x < 24; x++) add_read(x, y);
    add_read(0, 0); add_read(636, 476); add_read(700, 100); add_read(100, 500); add_read(639, 479);
    run_reads("ws");
  endtask

  task automatic test_oob_write;
    do_write(0, 0, 24'h010203, 1'b0);
    do_write(0, 1, 24'h343434, 1'b0);
    do_write(159, 119, 24'h0A0B0C, 1'b0);
    do_write(160, 0, 24'hFFFFFF, 1'b0);
    do_write(0, 120, 24'hFFFFFF, 1'b0);
    n_checks++; if (Write_ready !== 1'b1) $display("FAIL oob_ready got %b want 1", Write_ready); else n_pass++;
  endtask

  task automatic test_vblank_high;
    VBlank = 1'b1;
    tick; tick;
    Frame_Done = 1'b1; tick; Frame_Done = 1'b0;
    repeat (3) tick;
    n_checks++; if (Front_sel !== 1'b1) $display("FAIL vbh_hold_front got %b want 1", Front_sel); else n_pass++;
    n_checks++; if (Swap_count !== 16'd1) $display("FAIL vbh_hold_swaps got %0d want 1", Swap_count); else n_pass++;
    n_checks++; if (Write_ready !== 1'b0) $display("FAIL vbh_hold_ready got %b want 0", Write_ready); else n_pass++;
    VBlank = 1'b0; tick;
    VBlank = 1'b1; tick; tick;
    n_checks++; if (Front_sel !== 1'b0) $display("FAIL vbh_front got %b want 0", Front_sel); else n_pass++;
    n_checks++; if (Write_ready !== 1'b1) $display("FAIL vbh_ready got %b want 1", Write_ready); else n_pass++;
    tick; tick;
    n_checks++; if (Swap_count !== 16'd2) $display("FAIL vbh_swaps got %0d want 2", Swap_count); else n_pass++;
    exp_front = 1'b0;
    VBlank = 1'b0; tick;
    add_read(0, 0); add_read(3, 3); add_read(0, 4); add_read(2, 7);
    add_read(636, 476); add_read(639, 479); add_read(640, 0); add_read(0, 480);
    run_reads("oob");
  endtask

  task automatic test_dropped;
    do_write(1, 1, 24'h777777, 1'b1);
    Frame_Done = 1'b1; tick; Frame_Done = 1'b0;
    n_checks++; if (Dropped !== 8'd1) $display("FAIL drop_count got %0d want 1", Dropped); else n_pass++;
    VBlank = 1'b1; tick; tick;
    n_checks++; if (Front_sel !== 1'b1) $display("FAIL drop_front got %b want 1", Front_sel); else n_pass++;
    n_checks++; if (Swap_count !== 16'd3) $display("FAIL drop_swaps got %0d want 3", Swap_count); else n_pass++;
    tick; tick;
    n_checks++; if (Front_sel !== 1'b1) $display("FAIL drop_once got %b want 1", Front_sel); else n_pass++;
    exp_front = 1'b1;
    VBlank = 1'b0; tick;
    add_read(4, 4); add_read(20, 28); add_read(0, 0); add_read(636, 476);
    run_reads("drop");
  endtask

  task automatic test_reset_mid_swap;
    Frame_Done = 1'b1; tick; Frame_Done = 1'b0;
    VBlank = 1'b1; tick;
    n_checks++; if (Front_sel !== 1'b1) $display("FAIL rms_pre_front got %b want 1", Front_sel); else n_pass++;
    #1 Reset_n = 1'b0;
    #1;
    n_checks++; if (Front_sel !== 1'b0) $display("FAIL rms_front got %b want 0", Front_sel); else n_pass++;
    n_checks++; if (Write_ready !== 1'b1) $display("FAIL rms_ready got %b want 1", Write_ready); else n_pass++;
    n_checks++; if (Swap_count !== 16'd0) $display("FAIL rms_swaps got %0d want 0", Swap_count); else n_pass++;
    n_checks++; if (Dropped !== 8'd0) $display("FAIL rms_dropped got %0d want 0", Dropped); else n_pass++;
    n_checks++; if (ReadColor !== 24'h0) $display("FAIL rms_color got %h want 0", ReadColor); else n_pass++;
    VBlank = 1'b0;
    tick;
    Reset_n = 1'b1;
    exp_front = 1'b0;
    tick; tick;
    n_checks++; if (Front_sel !== 1'b0) $display("FAIL rms_post_front got %b want 0", Front_sel); else n_pass++;
    n_checks++; if (Write_ready !== 1'b1) $display("FAIL rms_post_ready got %b want 1", Write_ready); else n_pass++;
    add_read(0, 0); add_read(637, 477);
    run_reads("rms");
  endtask

  task automatic test_dropped_saturate;
    Frame_Done = 1'b1; tick; Frame_Done = 1'b0; tick;
    repeat (200) begin Frame_Done = 1'b1; tick; Frame_Done = 1'b0; tick; end
    n_checks++; if (Dropped !== 8'd200) $display("FAIL sat_mid got %0d want 200", Dropped); else n_pass++;
    repeat (60) begin Frame_Done = 1'b1; tick; Frame_Done = 1'b0; tick; end
    n_checks++; if (Dropped !== 8'd255) $display("FAIL sat_end got %0d want 255", Dropped); else n_pass++;
    n_checks++; if (Front_sel !== 1'b0) $display("FAIL sat_front got %b want 0", Front_sel); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_write_swap;
    test_oob_write;
    test_vblank_high;
    test_dropped;
    test_reset_mid_swap;
    test_dropped_saturate;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
